calc_key_sequencer: RTL and testbench

CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

---
 rtl/calc_key_sequencer.sv | 171 +++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer.sv
// Keypad sequencer for a 4-digit BCD calculator.
// Collects two operands and an operator, then latches the external ALU result.
module calc_key_sequencer #(
   parameter logic [3:0] KEY_ADD = 4'hA,
   parameter logic [3:0] KEY_SUB = 4'hB,
   parameter logic [3:0] KEY_EQ  = 4'hC,
   parameter logic [3:0] KEY_CLR = 4'hD
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        key_ready,
   input  logic [15:0] alu_result,
   output logic [15:0] num1_bcd,
   output logic [15:0] num2_bcd,
   output logic [1:0]  operation,
   output logic [15:0] display_bcd,
   output logic        result_valid
);

   typedef enum logic [1:0] {
      ENTER_A,
      ENTER_B,
      EXEC,
      RESULT
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [2:0]  cnt_q;
   logic [2:0]  cnt_d;
   logic [15:0] num1_d;
   logic [15:0] num2_d;
   logic [15:0] disp_d;
   logic [1:0]  op_d;
   logic        rv_d;

   logic        take;
   logic        legal;
   logic        is_dig;
   logic        is_add;
   logic        is_sub;
   logic        is_op;
   logic        is_eq;
   logic        is_clr;
   logic        cnt_full;
   logic [1:0]  op_key;
   logic [15:0] n1_shift;
   logic [15:0] n2_shift;

   assign key_ready = (state_q != EXEC);
   assign take      = key_valid && key_ready;
   // Codes E and F never act, whatever the parameters are set to.
   assign legal     = (key_code < 4'hE);
   assign is_dig    = take && (key_code <= 4'd9);
   assign is_add    = take && legal && (key_code == KEY_ADD);
   assign is_sub    = take && legal && (key_code == KEY_SUB);
   assign is_eq     = take && legal && (key_code == KEY_EQ);
   assign is_clr    = take && legal && (key_code == KEY_CLR);
   assign is_op     = is_add || is_sub;
   assign op_key    = is_add ? 2'b01 : 2'b10;
   assign cnt_full  = (cnt_q == 3'd4);
   assign n1_shift  = {num1_bcd[11:0], key_code};
   assign n2_shift  = {num2_bcd[11:0], key_code};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ENTER_A;
         cnt_q        <= 3'd0;
         num1_bcd     <= 16'h0000;
         num2_bcd     <= 16'h0000;
         operation    <= 2'b00;
         display_bcd  <= 16'h0000;
         result_valid <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         num1_bcd     <= num1_d;
         num2_bcd     <= num2_d;
         operation    <= op_d;
         display_bcd  <= disp_d;
         result_valid <= rv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      num1_d  = num1_bcd;
      num2_d  = num2_bcd;
      op_d    = operation;
      disp_d  = display_bcd;
      rv_d    = result_valid;
      if (is_clr) begin
         state_d = ENTER_A;
         cnt_d   = 3'd0;
         num1_d  = 16'h0000;
         num2_d  = 16'h0000;
         op_d    = 2'b00;
         disp_d  = 16'h0000;
         rv_d    = 1'b0;
      end else begin
         unique case (state_q)
            ENTER_A: begin
               unique case (1'b1)
                  is_dig: begin
                     if (!cnt_full) begin
                        num1_d = n1_shift;
                        cnt_d  = cnt_q + 3'd1;
                        disp_d = n1_shift;
                     end
                  end
                  is_op: begin
                     op_d    = op_key;
                     num2_d  = 16'h0000;
                     cnt_d   = 3'd0;
                     state_d = ENTER_B;
                  end
                  default: ;
               endcase
            end
            ENTER_B: begin
               unique case (1'b1)
                  is_dig: begin
                     if (!cnt_full) begin
                        num2_d = n2_shift;
                        cnt_d  = cnt_q + 3'd1;
                        disp_d = n2_shift;
                     end
                  end
                  is_op:   op_d = op_key;
                  is_eq:   state_d = EXEC;
                  default: ;
               endcase
            end
            EXEC: begin
               // Result becomes the next left operand so chaining works.
               disp_d  = alu_result;
               num1_d  = alu_result;
               rv_d    = 1'b1;
               state_d = RESULT;
            end
            RESULT: begin
               unique case (1'b1)
                  is_dig: begin
                     num1_d  = {12'h000, key_code};
                     cnt_d   = 3'd1;
                     num2_d  = 16'h0000;
                     op_d    = 2'b00;
                     disp_d  = {12'h000, key_code};
                     rv_d    = 1'b0;
                     state_d = ENTER_A;
                  end
                  is_op: begin
                     op_d    = op_key;
                     num2_d  = 16'h0000;
                     cnt_d   = 3'd0;
                     rv_d    = 1'b0;
                     state_d = ENTER_B;
                  end
                  is_eq:   state_d = EXEC;
                  default: ;
               endcase
            end
            default: state_d = ENTER_A;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed key tables, corner sequences
// and random keys against a decimal-arithmetic reference model.
module tb_calc_key_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        key_ready;
   logic [15:0] alu_result;
   logic [15:0] num1_bcd;
   logic [15:0] num2_bcd;
   logic [1:0]  operation;
   logic [15:0] display_bcd;
   logic        result_valid;

   int vectors = 0;
   int miscompares = 0;

   calc_key_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_ready    (key_ready),
      .alu_result   (alu_result),
      .num1_bcd     (num1_bcd),
      .num2_bcd     (num2_bcd),
      .operation    (operation),
      .display_bcd  (display_bcd),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   function automatic int from_bcd(input logic [15:0] b);
      return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   function automatic int alu_int(input int a, input int b, input int op);
      int r;
      r = a;
      if (op == 1) r = a + b;
      if (op == 2) r = a - b;
      if (r > 9999) r = 9999;
      if (r < 0) r = 0;
      return r;
   endfunction

   // Downstream saturating BCD ALU.
   always_comb alu_result = to_bcd(alu_int(from_bcd(num1_bcd),
                                           from_bcd(num2_bcd),
                                           int'(operation)));

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);
   endtask

   // Reference model: phase 0=A entry, 1=B entry, 2=executing, 3=showing.
   int m_ph, m_cnt, m_a, m_b, m_op, m_disp, m_rv;

   task automatic m_reset();
      m_ph = 0; m_cnt = 0; m_a = 0; m_b = 0;
      m_op = 0; m_disp = 0; m_rv = 0;
   endtask

   task automatic m_step(input logic kv, input logic [3:0] kc);
      int d;
      bit dig, opk, eq;
      if (m_ph == 2) begin
         m_a = alu_int(m_a, m_b, m_op);
         m_disp = m_a;
         m_rv = 1;
         m_ph = 3;
         return;
      end
      if (!kv) return;
      d   = int'(kc);
      dig = (d <= 9);
      opk = (kc == 4'hA) || (kc == 4'hB);
      eq  = (kc == 4'hC);
      if (kc == 4'hD) begin
         m_reset();
         return;
      end
      case (m_ph)
         0: begin
            if (dig && m_cnt < 4) begin
               m_a = m_a * 10 + d; m_cnt++; m_disp = m_a;
            end else if (opk) begin
               m_op = (kc == 4'hA) ? 1 : 2; m_b = 0; m_cnt = 0; m_ph = 1;
            end
         end
         1: begin
            if (dig && m_cnt < 4) begin
               m_b = m_b * 10 + d; m_cnt++; m_disp = m_b;
            end else if (opk) m_op = (kc == 4'hA) ? 1 : 2;
            else if (eq) m_ph = 2;
         end
         3: begin
            if (dig) begin
               m_a = d; m_cnt = 1; m_b = 0; m_op = 0;
               m_disp = d; m_rv = 0; m_ph = 0;
            end else if (opk) begin
               m_op = (kc == 4'hA) ? 1 : 2; m_b = 0; m_cnt = 0;
               m_rv = 0; m_ph = 1;
            end else if (eq) m_ph = 2;
         end
         default: ;
      endcase
   endtask

   typedef struct {
      logic [3:0]  code;
      logic [15:0] disp;
      logic        rv;
      logic [15:0] n1;
      logic [15:0] n2;
      logic [1:0]  op;
   } vec_t;

   vec_t tbl[$];

   initial begin
      tbl.push_back('{4'hD, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0});
      tbl.push_back('{4'h1, 16'h0001, 1'b0, 16'h0001, 16'h0000, 2'd0});
      tbl.push_back('{4'h2, 16'h0012, 1'b0, 16'h0012, 16'h0000, 2'd0});
      tbl.push_back('{4'hA, 16'h0012, 1'b0, 16'h0012, 16'h0000, 2'd1});
      tbl.push_back('{4'h3, 16'h0003, 1'b0, 16'h0012, 16'h0003, 2'd1});
      tbl.push_back('{4'h4, 16'h0034, 1'b0, 16'h0012, 16'h0034, 2'd1});
      tbl.push_back('{4'hC, 16'h0046, 1'b1, 16'h0046, 16'h0034, 2'd1});
      tbl.push_back('{4'hD, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0});
      tbl.push_back('{4'h9, 16'h0009, 1'b0, 16'h0009, 16'h0000, 2'd0});
      tbl.push_back('{4'h9, 16'h0099, 1'b0, 16'h0099, 16'h0000, 2'd0});
      tbl.push_back('{4'h9, 16'h0999, 1'b0, 16'h0999, 16'h0000, 2'd0});
      tbl.push_back('{4'h9, 16'h9999, 1'b0, 16'h9999, 16'h0000, 2'd0});
      tbl.push_back('{4'hA, 16'h9999, 1'b0, 16'h9999, 16'h0000, 2'd1});
      tbl.push_back('{4'h1, 16'h0001, 1'b0, 16'h9999, 16'h0001, 2'd1});
      tbl.push_back('{4'hC, 16'h9999, 1'b1, 16'h9999, 16'h0001, 2'd1});
      tbl.push_back('{4'hD, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0});
      tbl.push_back('{4'h5, 16'h0005, 1'b0, 16'h0005, 16'h0000, 2'd0});
      tbl.push_back('{4'hB, 16'h0005, 1'b0, 16'h0005, 16'h0000, 2'd2});
      tbl.push_back('{4'h7, 16'h0007, 1'b0, 16'h0005, 16'h0007, 2'd2});
      tbl.push_back('{4'hC, 16'h0000, 1'b1, 16'h0000, 16'h0007, 2'd2});
      tbl.push_back('{4'hD, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0});
      tbl.push_back('{4'h1, 16'h0001, 1'b0, 16'h0001, 16'h0000, 2'd0});
      tbl.push_back('{4'h2, 16'h0012, 1'b0, 16'h0012, 16'h0000, 2'd0});
      tbl.push_back('{4'h3, 16'h0123, 1'b0, 16'h0123, 16'h0000, 2'd0});
      tbl.push_back('{4'h4, 16'h1234, 1'b0, 16'h1234, 16'h0000, 2'd0});
      tbl.push_back('{4'h5, 16'h1234, 1'b0, 16'h1234, 16'h0000, 2'd0});
      tbl.push_back('{4'hF, 16'h1234, 1'b0, 16'h1234, 16'h0000, 2'd0});
      tbl.push_back('{4'hC, 16'h1234, 1'b0, 16'h1234, 16'h0000, 2'd0});
      tbl.push_back('{4'hD, 16'h0000, 1'b0, 16'h0000, 16'h0000, 2'd0});
      tbl.push_back('{4'h1, 16'h0001, 1'b0, 16'h0001, 16'h0000, 2'd0});
      tbl.push_back('{4'h0, 16'h0010, 1'b0, 16'h0010, 16'h0000, 2'd0});
      tbl.push_back('{4'hA, 16'h0010, 1'b0, 16'h0010, 16'h0000, 2'd1});
      tbl.push_back('{4'h5, 16'h0005, 1'b0, 16'h0010, 16'h0005, 2'd1});
      tbl.push_back('{4'hC, 16'h0015, 1'b1, 16'h0015, 16'h0005, 2'd1});
      tbl.push_back('{4'hF, 16'h0015, 1'b1, 16'h0015, 16'h0005, 2'd1});
      tbl.push_back('{4'hC, 16'h0020, 1'b1, 16'h0020, 16'h0005, 2'd1});
      tbl.push_back('{4'hB, 16'h0020, 1'b0, 16'h0020, 16'h0000, 2'd2});
      tbl.push_back('{4'hA, 16'h0020, 1'b0, 16'h0020, 16'h0000, 2'd1});
      tbl.push_back('{4'h3, 16'h0003, 1'b0, 16'h0020, 16'h0003, 2'd1});
      tbl.push_back('{4'hC, 16'h0023, 1'b1, 16'h0023, 16'h0003, 2'd1});
      tbl.push_back('{4'h7, 16'h0007, 1'b0, 16'h0007, 16'h0000, 2'd0});

      // Reset state.
      #12;
      chk("rst_disp", display_bcd, 16'h0000);
      chk("rst_rv", 16'(result_valid), 16'h0000);
      chk("rst_n1", num1_bcd, 16'h0000);
      chk("rst_n2", num2_bcd, 16'h0000);
      chk("rst_op", 16'(operation), 16'h0000);
      chk("rst_rdy", 16'(key_ready), 16'h0001);
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         press(tbl[i].code);
         chk($sformatf("tbl%0d_disp", i), display_bcd, tbl[i].disp);
         chk($sformatf("tbl%0d_rv", i), 16'(result_valid), 16'(tbl[i].rv));
         chk($sformatf("tbl%0d_n1", i), num1_bcd, tbl[i].n1);
         chk($sformatf("tbl%0d_n2", i), num2_bcd, tbl[i].n2);
         chk($sformatf("tbl%0d_op", i), 16'(operation), 16'(tbl[i].op));
      end

      // Key strobe during EXEC is dropped.
      press(4'hD); press(4'h2); press(4'hA); press(4'h3);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'hC;
      @(negedge clk);
      chk("exec_rdy", 16'(key_ready), 16'h0000);
      key_code = 4'h9;
      @(negedge clk);
      key_valid = 1'b0;
      chk("exec_disp", display_bcd, 16'h0005);
      chk("exec_rv", 16'(result_valid), 16'h0001);
      chk("exec_rdy_after", 16'(key_ready), 16'h0001);
      @(negedge clk);
      chk("exec_drop", display_bcd, 16'h0005);

      // Reset during EXEC latches nothing.
      press(4'hD); press(4'h2); press(4'hA); press(4'h3);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'hC;
      @(negedge clk);
      key_valid = 1'b0;
      chk("rexec_rdy", 16'(key_ready), 16'h0000);
      reset_n = 1'b0;
      #1;
      chk("rexec_disp", display_bcd, 16'h0000);
      chk("rexec_n1", num1_bcd, 16'h0000);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rexec_rv", 16'(result_valid), 16'h0000);
      chk("rexec_disp2", display_bcd, 16'h0000);
      press(4'h4);
      chk("rexec_first", display_bcd, 16'h0004);

      // Reset pulsed in ENTER_B clears outputs immediately.
      press(4'hD); press(4'h1); press(4'hA); press(4'h2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rb_disp", display_bcd, 16'h0000);
      chk("rb_n1", num1_bcd, 16'h0000);
      chk("rb_n2", num2_bcd, 16'h0000);
      chk("rb_op", 16'(operation), 16'h0000);
      #1;
      reset_n = 1'b1;

      // Random keys against the reference model.
      m_reset();
      for (int i = 0; i < 3000; i++) begin
         logic        kv;
         logic [3:0]  kc;
         int          r;
         @(negedge clk);
         chk("rnd_disp", display_bcd, to_bcd(m_disp));
         chk("rnd_rv", 16'(result_valid), 16'(m_rv));
         chk("rnd_n1", num1_bcd, to_bcd(m_a));
         chk("rnd_n2", num2_bcd, to_bcd(m_b));
         chk("rnd_op", 16'(operation), 16'(m_op));
         chk("rnd_rdy", 16'(key_ready), 16'(m_ph != 2));
         if (i % 700 == 350) begin
            reset_n = 1'b0;
            #1;
            reset_n = 1'b1;
            m_reset();
         end
         kv = ($urandom_range(0, 2) != 0);
         r  = $urandom_range(0, 99);
         if (r < 55)      kc = 4'($urandom_range(0, 9));
         else if (r < 67) kc = 4'hA;
         else if (r < 79) kc = 4'hB;
         else if (r < 91) kc = 4'hC;
         else if (r < 94) kc = 4'hD;
         else             kc = 4'($urandom_range(14, 15));
         key_valid = kv;
         key_code  = kc;
         m_step(kv, kc);
      end
      @(negedge clk);
      key_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
